// File: rtl/acknak_gen.sv
// ---------------------------------------------------------------------------
// acknak_gen
//   Receive-side data-link ACK/NAK generator. Each received TLP is classified
//   against NEXT_RCV_SEQ (NRS) and its LCRC status. Good TLPs are forwarded and
//   acknowledged in coalesced batches. Duplicates force an ACK. Bad or
//   out-of-sequence TLPs schedule a single NAK. The NAK is re-armed only after
//   the next good TLP. A timer forces an ACK when good TLPs wait too long.
//
// Ports
//   clk           in   1      system clock, rising edge
//   reset         in   1      asynchronous, active-high reset
//   tlp_valid     in   1      one-cycle strobe: TLP fully received
//   tlp_seq       in   SEQ_W  sequence number of that TLP
//   tlp_crc_ok    in   1      LCRC of that TLP passed
//   tlp_accept    out  1      registered pulse: TLP forwarded upstream
//   acknak_valid  out  1      ACK/NAK request valid
//   acknak_rdy    in   1      transmitter takes the request
//   acknak_o      out  2      01 = ACK, 10 = NAK, 00 when not valid
//   acknak_seq    out  SEQ_W  NRS-1 captured when the request was raised
//   next_rcv_seq  out  SEQ_W  current NEXT_RCV_SEQ
//   nak_sched     out  1      NAK_SCHEDULED flag
// ---------------------------------------------------------------------------
module acknak_gen #(
  parameter int SEQ_W        = 12,
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 64,
  parameter int TIMER_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tlp_valid,
  input  logic [SEQ_W-1:0] tlp_seq,
  input  logic             tlp_crc_ok,
  output logic             tlp_accept,
  output logic             acknak_valid,
  input  logic             acknak_rdy,
  output logic [1:0]       acknak_o,
  output logic [SEQ_W-1:0] acknak_seq,
  output logic [SEQ_W-1:0] next_rcv_seq,
  output logic             nak_sched
);

  // Pending count only needs to reach ACK_COALESCE; a wider counter that
  // saturates keeps the batch test simple when the transmitter stalls.
  localparam int PEND_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK_REQ = 2'd1,
    ST_NAK_REQ = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEQ_W-1:0]  r_nrs;
  logic [SEQ_W-1:0]  w_nrs_nxt;
  logic [SEQ_W-1:0]  w_dist;
  logic [SEQ_W-1:0]  r_acknak_seq;
  logic [SEQ_W-1:0]  w_acknak_seq_nxt;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_pending_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic              r_nak_pend;
  logic              w_nak_pend_nxt;
  logic              r_nak_sched;
  logic              w_nak_sched_nxt;
  logic              r_ack_force;
  logic              w_ack_force_nxt;
  logic              r_accept;
  logic              w_good;
  logic              w_dup;
  logic              w_nak_cond;
  logic              w_ack_taken;
  logic              w_nak_taken;
  logic              w_ack_due;

  // Distance behind NRS, modulo 2^SEQ_W. Zero is the expected TLP; the lower
  // half of the ring (excluding zero) is already-received traffic.
  assign w_dist     = r_nrs - tlp_seq;
  assign w_good     = tlp_valid & tlp_crc_ok & (w_dist == '0);
  assign w_dup      = tlp_valid & tlp_crc_ok & (w_dist != '0) & ~w_dist[SEQ_W-1];
  // Bad CRC or out-of-sequence; only the first one after a good TLP counts.
  assign w_nak_cond = tlp_valid & ~(w_good | w_dup) & ~r_nak_sched;

  assign w_ack_taken = (r_state == ST_ACK_REQ) & acknak_rdy;
  assign w_nak_taken = (r_state == ST_NAK_REQ) & acknak_rdy;

  // Link-state updates. Everything here is the value after this cycle's TLP,
  // so a request raised this cycle already reflects it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_nrs_nxt       = r_nrs;
    w_pending_nxt   = r_pending;
    w_timer_nxt     = r_timer;
    w_nak_pend_nxt  = r_nak_pend;
    w_nak_sched_nxt = r_nak_sched;
    w_ack_force_nxt = r_ack_force;

    if (w_good) begin
      w_nrs_nxt = r_nrs + SEQ_W'(1);
    end

    // A NAK acknowledges NRS-1 as well, so it retires the whole batch.
    if (w_nak_taken) begin
      w_pending_nxt = '0;
    end else if (w_ack_taken) begin
      w_pending_nxt = w_good ? PEND_W'(1) : '0;
    end else if (w_good && (r_pending != '1)) begin
      w_pending_nxt = r_pending + PEND_W'(1);
    end

    if (w_ack_taken || w_nak_taken) begin
      w_timer_nxt = '0;
    end else if ((r_state == ST_IDLE) && (r_pending != '0) &&
                 (r_timer != TIMER_W'(ACK_TIMEOUT))) begin
      w_timer_nxt = r_timer + TIMER_W'(1);
    end

    // A fresh NAK condition wins over the clear of the one being taken.
    w_nak_pend_nxt  = (r_nak_pend & ~w_nak_taken) | w_nak_cond;
    w_ack_force_nxt = (r_ack_force & ~w_ack_taken) | w_dup;

    if (w_good) begin
      w_nak_sched_nxt = 1'b0;
    end else if (w_nak_cond) begin
      w_nak_sched_nxt = 1'b1;
    end
  end

  assign w_ack_due = (w_pending_nxt >= PEND_W'(ACK_COALESCE)) || w_ack_force_nxt ||
                     ((w_pending_nxt != '0) && (w_timer_nxt == TIMER_W'(ACK_TIMEOUT)));

  // Request FSM: next state and the captured AckNak sequence number.
  always_comb begin
    w_state_nxt      = r_state;
    w_acknak_seq_nxt = r_acknak_seq;
    case (r_state)
      ST_IDLE: begin
        if (w_nak_pend_nxt) begin
          w_state_nxt      = ST_NAK_REQ;
          w_acknak_seq_nxt = w_nrs_nxt - SEQ_W'(1);
        end else if (w_ack_due) begin
          w_state_nxt      = ST_ACK_REQ;
          w_acknak_seq_nxt = w_nrs_nxt - SEQ_W'(1);
        end
      end
      ST_ACK_REQ, ST_NAK_REQ: begin
        if (acknak_rdy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_nrs        <= '0;
      r_acknak_seq <= '0;
      r_pending    <= '0;
      r_timer      <= '0;
      r_nak_pend   <= 1'b0;
      r_nak_sched  <= 1'b0;
      r_ack_force  <= 1'b0;
      r_accept     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_state      <= w_state_nxt;
      r_nrs        <= w_nrs_nxt;
      r_acknak_seq <= w_acknak_seq_nxt;
      r_pending    <= w_pending_nxt;
      r_timer      <= w_timer_nxt;
      r_nak_pend   <= w_nak_pend_nxt;
      r_nak_sched  <= w_nak_sched_nxt;
      r_ack_force  <= w_ack_force_nxt;
      r_accept     <= w_good;
    end
  end

  // Valid and code come straight from the state register, so an asynchronous
  // reset drops a request in flight immediately.
  assign acknak_valid = (r_state != ST_IDLE);
  assign acknak_o     = {r_state == ST_NAK_REQ, r_state == ST_ACK_REQ};
  assign acknak_seq   = r_acknak_seq;
  assign next_rcv_seq = r_nrs;
  assign nak_sched    = r_nak_sched;
  assign tlp_accept   = r_accept;

endmodule

// File: tb/tb_acknak_gen.sv
// ---------------------------------------------------------------------------
// tb_acknak_gen
//   Directed stimulus for acknak_gen. A cycle model built from the link rules
//   on plain integers predicts every output; it is compared on each falling
//   edge, and hand-computed literals pin both the DUT and the model.
// ---------------------------------------------------------------------------
module tb_acknak_gen;

  localparam int SEQ_W        = 12;
  localparam int SEQ_MOD      = 1 << SEQ_W;
  localparam int ACK_COALESCE = 4;
  localparam int ACK_TIMEOUT  = 64;
  localparam int TIMER_W      = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tlp_valid = 1'b0;
  logic [SEQ_W-1:0] tlp_seq = '0;
  logic             tlp_crc_ok = 1'b0;
  logic             tlp_accept;
  logic             acknak_valid;
  logic             acknak_rdy = 1'b1;
  logic [1:0]       acknak_o;
  logic [SEQ_W-1:0] acknak_seq;
  logic [SEQ_W-1:0] next_rcv_seq;
  logic             nak_sched;

  int n_total = 0;
  int n_bad   = 0;

  acknak_gen #(
    .SEQ_W        (SEQ_W),
    .ACK_COALESCE (ACK_COALESCE),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .TIMER_W      (TIMER_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tlp_valid    (tlp_valid),
    .tlp_seq      (tlp_seq),
    .tlp_crc_ok   (tlp_crc_ok),
    .tlp_accept   (tlp_accept),
    .acknak_valid (acknak_valid),
    .acknak_rdy   (acknak_rdy),
    .acknak_o     (acknak_o),
    .acknak_seq   (acknak_seq),
    .next_rcv_seq (next_rcv_seq),
    .nak_sched    (nak_sched)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Link model. req: 0 none, 1 ACK outstanding, 2 NAK outstanding.
  // ---------------------------------------------------------------------
  typedef struct packed {
    int nrs;
    int pending;       // good TLPs not yet covered by a taken ACK/NAK
    int idle_wait;     // idle cycles spent with good TLPs waiting
    int req;
    int req_seq;
    int acks;          // ACKs taken by the transmitter
    int naks;          // NAKs taken by the transmitter
    int last_ack_seq;
    bit accept;
    bit nak_sched;
    bit nak_pend;
    bit ack_force;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t step(input mstate_t s, input bit v, input int seq,
                                   input bit crc, input bit rdy);
    mstate_t n;
    int      behind;
    bit      good;
    bit      dup;
    bit      flag;
    bit      ack_done;
    bit      nak_done;
    n        = s;
    behind   = (s.nrs - seq + SEQ_MOD) % SEQ_MOD;
    good     = v && crc && (behind == 0);
    dup      = v && crc && (behind >= 1) && (behind <= SEQ_MOD / 2 - 1);
    flag     = v && !good && !dup;
    ack_done = (s.req == 1) && rdy;
    nak_done = (s.req == 2) && rdy;

    n.accept = good;
    if (good) n.nrs = (s.nrs + 1) % SEQ_MOD;

    if (nak_done)                       n.pending = 0;
    else if (ack_done)                  n.pending = good ? 1 : 0;
    else if (good && s.pending < 255)   n.pending = s.pending + 1;

    if (ack_done || nak_done)
      n.idle_wait = 0;
    else if (s.req == 0 && s.pending > 0 && s.idle_wait < ACK_TIMEOUT)
      n.idle_wait = s.idle_wait + 1;

    n.ack_force = (s.ack_force && !ack_done) || dup;
    if (nak_done) n.nak_pend = 1'b0;
    if (flag && !s.nak_sched) begin
      n.nak_sched = 1'b1;
      n.nak_pend  = 1'b1;
    end
    if (good) n.nak_sched = 1'b0;

    if (s.req != 0) begin
      if (rdy) begin
        n.req = 0;
        if (ack_done) begin
          n.acks         = s.acks + 1;
          n.last_ack_seq = s.req_seq;
        end else begin
          n.naks = s.naks + 1;
        end
      end
    end else if (n.nak_pend) begin
      n.req     = 2;
      n.req_seq = (n.nrs + SEQ_MOD - 1) % SEQ_MOD;
    end else if (n.pending >= ACK_COALESCE || n.ack_force ||
                 (n.pending > 0 && n.idle_wait == ACK_TIMEOUT)) begin
      n.req     = 1;
      n.req_seq = (n.nrs + SEQ_MOD - 1) % SEQ_MOD;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, tlp_valid, int'(tlp_seq), tlp_crc_ok, acknak_rdy);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("cmp_accept", tlp_accept, m.accept);
    check("cmp_valid", acknak_valid, m.req != 0);
    check("cmp_code", acknak_o, (m.req == 1) ? 2'b01 : (m.req == 2) ? 2'b10 : 2'b00);
    check("cmp_seq", acknak_seq, m.req_seq);
    check("cmp_nrs", next_rcv_seq, m.nrs);
    check("cmp_nak_sched", nak_sched, m.nak_sched);
  end

  // One cycle of stimulus, applied just after the falling edge.
  task automatic cyc(input bit v, input int seq, input bit crc);
    @(negedge clk);
    tlp_valid  = v;
    tlp_seq    = SEQ_W'(seq % SEQ_MOD);
    tlp_crc_ok = crc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    tlp_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;

    // ---- 1: reset, four back-to-back good TLPs -> one ACK seq 3 ----
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", acknak_valid, 0);
    check("rst_code", acknak_o, 0);
    check("rst_seq", acknak_seq, 0);
    check("rst_nrs", next_rcv_seq, 0);
    check("rst_accept", tlp_accept, 0);
    check("rst_nak_sched", nak_sched, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      cyc(1, i, 1);
      if (i > 0) check("t1_accept", tlp_accept, 1);
      check("t1_no_early_ack", acknak_valid, 0);
    end
    cyc(0, 0, 0);
    check("t1_accept_last", tlp_accept, 1);
    check("t1_ack_valid", acknak_valid, 1);
    check("t1_ack_code", acknak_o, 2'b01);
    check("t1_ack_seq", acknak_seq, 3);
    cyc(0, 0, 0);
    check("t1_nrs", next_rcv_seq, 4);
    check("t1_valid_dropped", acknak_valid, 0);
    check("t1_model_acks", m.acks, 1);
    check("t1_model_last_ack", m.last_ack_seq, 3);

    // ---- 2: single good TLP, ACK forced by the timer ----
    // The loop's first pass already sees pending=1, so the ACK shows up on
    // pass ACK_TIMEOUT+1.
    cyc(1, 4, 1);
    n = 0;
    do begin
      cyc(0, 0, 0);
      n++;
    end while (!acknak_valid && n < 200);
    check("t2_timeout_cycles", n, ACK_TIMEOUT + 1);
    check("t2_ack_code", acknak_o, 2'b01);
    check("t2_ack_seq", acknak_seq, 4);

    // ---- 3: bad CRC -> NAK seq 4; second bad dropped; good clears ----
    cyc(1, 5, 0);
    check("t3_idle_before_nak", acknak_valid, 0);
    cyc(1, 6, 0);
    check("t3_nak_valid", acknak_valid, 1);
    check("t3_nak_code", acknak_o, 2'b10);
    check("t3_nak_seq", acknak_seq, 4);
    check("t3_nak_sched_set", nak_sched, 1);
    cyc(0, 0, 0);
    check("t3_nak_taken", acknak_valid, 0);
    cyc(1, 5, 1);
    check("t3_no_second_nak", acknak_valid, 0);
    check("t3_sched_held", nak_sched, 1);
    cyc(0, 0, 0);
    check("t3_retry_accept", tlp_accept, 1);
    check("t3_sched_cleared", nak_sched, 0);
    check("t3_nrs", next_rcv_seq, 6);
    check("t3_model_naks", m.naks, 1);

    // ---- 4: duplicate -> immediate ACK seq 5; far-off seq -> NAK seq 5 ----
    cyc(1, 2, 1);
    cyc(0, 0, 0);
    check("t4_dup_no_accept", tlp_accept, 0);
    check("t4_dup_ack_valid", acknak_valid, 1);
    check("t4_dup_ack_code", acknak_o, 2'b01);
    check("t4_dup_ack_seq", acknak_seq, 5);
    check("t4_dup_nrs", next_rcv_seq, 6);
    cyc(1, 100, 1);
    cyc(0, 0, 0);
    check("t4_oos_no_accept", tlp_accept, 0);
    check("t4_oos_nak_code", acknak_o, 2'b10);
    check("t4_oos_nak_seq", acknak_seq, 5);
    cyc(0, 0, 0);

    // ---- 5: stalled ACK stays stable; bad TLP meanwhile -> NAK after ----
    acknak_rdy = 1'b0;
    for (int i = 6; i < 10; i++) cyc(1, i, 1);
    cyc(0, 0, 0);
    check("t5_ack_valid", acknak_valid, 1);
    check("t5_ack_seq", acknak_seq, 9);
    for (int k = 0; k < 10; k++) begin
      cyc(k == 3, 10, 0);
      check("t5_hold_valid", acknak_valid, 1);
      check("t5_hold_code", acknak_o, 2'b01);
      check("t5_hold_seq", acknak_seq, 9);
    end
    cyc(0, 0, 0);
    acknak_rdy = 1'b1;
    check("t5_sched_during_ack", nak_sched, 1);
    n = 0;
    do begin
      cyc(0, 0, 0);
      n++;
    end while (!(acknak_valid && acknak_o == 2'b10) && n < 8);
    check("t5_nak_after_ack_cycles", n, 2);
    check("t5_nak_seq", acknak_seq, 9);
    cyc(0, 0, 0);

    // ---- 6: 4100 good TLPs wrap NRS; final ACK seq 3 ----
    do_reset();
    for (int i = 0; i < 4100; i++) begin
      cyc(1, i, 1);
      if (i == 4095) check("t6_nrs_max", next_rcv_seq, 12'hFFF);
      if (i == 4096) check("t6_nrs_wrap", next_rcv_seq, 12'h000);
    end
    cyc(0, 0, 0);
    check("t6_final_ack_valid", acknak_valid, 1);
    check("t6_final_ack_code", acknak_o, 2'b01);
    check("t6_final_ack_seq", acknak_seq, 12'h003);
    cyc(0, 0, 0);
    check("t6_final_nrs", next_rcv_seq, 4);
    check("t6_model_acks", m.acks, 1025);
    check("t6_model_last_ack", m.last_ack_seq, 3);

    // ---- reset in the middle of a stalled ACK ----
    acknak_rdy = 1'b0;
    for (int i = 4; i < 8; i++) cyc(1, i, 1);
    cyc(0, 0, 0);
    check("rmid_ack_valid", acknak_valid, 1);
    check("rmid_ack_seq", acknak_seq, 7);
    #2 reset = 1'b1;
    #1;
    check("rmid_valid_drop", acknak_valid, 0);
    check("rmid_code_drop", acknak_o, 0);
    check("rmid_nrs_drop", next_rcv_seq, 0);
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    acknak_rdy = 1'b1;
    repeat (3) cyc(0, 0, 0);
    check("rmid_after_idle", acknak_valid, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
